// File: rtl/recompute_result_merge.sv
// recompute_result_merge
// Collects one ROWS x COLS tile of PE results. Healthy PEs come from the
// systolic array and faulty PEs (per the latched STW fault map) come from the
// recompute units. The repaired tile is then streamed out row-major over
// valid/ready.
// Ports:
//   clk, rst              clock, async active-high reset
//   STW_result_mat        fault map (1 = faulty PE), latched on start
//   start                 begin a new tile (honoured only when idle)
//   arr_valid/row/col/data array result write
//   ru_valid/ru_row/ru_col/BottomOut  per-recompute-unit result writes
//   out_valid/ready/data/row/col/last  repaired tile stream
//   busy                  block is not idle
//   merge_err             sticky protocol error for the current tile
module recompute_result_merge #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NUM_RU    = 4,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 STW_result_mat [0:ROWS-1][0:COLS-1],
    input  logic                 start,
    input  logic                 arr_valid,
    input  logic [RW-1:0]        arr_row,
    input  logic [CW-1:0]        arr_col,
    input  logic [WORD_SIZE-1:0] arr_data,
    input  logic [NUM_RU-1:0]    ru_valid,
    input  logic [RW-1:0]        ru_row    [0:NUM_RU-1],
    input  logic [CW-1:0]        ru_col    [0:NUM_RU-1],
    input  logic [WORD_SIZE-1:0] BottomOut [0:NUM_RU-1],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 merge_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] tile_buf [ROWS][COLS];
    logic                 filled   [ROWS][COLS];
    logic                 mask     [ROWS][COLS];

    logic                 we_c     [ROWS][COLS];
    logic [WORD_SIZE-1:0] wd_c     [ROWS][COLS];
    logic                 err_c;
    logic                 all_filled_c;
    logic [RW-1:0]        next_row_c;
    logic [CW-1:0]        next_col_c;

    // Per-cell write enables for this cycle; RUs are scanned in index order
    // so the lowest-numbered RU claims a contested cell first.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                we_c[r][c] = 1'b0;
                wd_c[r][c] = '0;
            end
        end
        err_c = 1'b0;
        if (state == COLLECT) begin
            if (arr_valid) begin
                if (32'(arr_row) < ROWS && 32'(arr_col) < COLS) begin
                    // Faulty-PE array output is expected and dropped quietly.
                    if (!mask[arr_row][arr_col]) begin
                        if (filled[arr_row][arr_col]) begin
                            err_c = 1'b1;
                        end else begin
                            we_c[arr_row][arr_col] = 1'b1;
                            wd_c[arr_row][arr_col] = arr_data;
                        end
                    end
                end else begin
                    err_c = 1'b1;
                end
            end
            for (int n = 0; n < NUM_RU; n++) begin
                if (ru_valid[n]) begin
                    if (32'(ru_row[n]) < ROWS && 32'(ru_col[n]) < COLS) begin
                        if (!mask[ru_row[n]][ru_col[n]] || filled[ru_row[n]][ru_col[n]]
                            || we_c[ru_row[n]][ru_col[n]]) begin
                            err_c = 1'b1;
                        end else begin
                            we_c[ru_row[n]][ru_col[n]] = 1'b1;
                            wd_c[ru_row[n]][ru_col[n]] = BottomOut[n];
                        end
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
        end
    end

    // Tile-complete detect on the registered fill map.
    always_comb begin
        all_filled_c = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                all_filled_c = all_filled_c & filled[r][c];
            end
        end
    end

    // Row-major successor of the current output position.
    always_comb begin
        next_row_c = out_row;
        next_col_c = out_col + CW'(1);
        if (out_col == CW'(COLS - 1)) begin
            next_col_c = '0;
            next_row_c = out_row + RW'(1);
        end
    end

    // Control FSM, storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            merge_err <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    tile_buf[r][c] <= '0;
                    filled[r][c]   <= 1'b0;
                    mask[r][c]     <= 1'b0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                mask[r][c]   <= STW_result_mat[r][c];
                                filled[r][c] <= 1'b0;
                            end
                        end
                        merge_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (we_c[r][c]) begin
                                tile_buf[r][c] <= wd_c[r][c];
                                filled[r][c]   <= 1'b1;
                            end
                        end
                    end
                    if (err_c) begin
                        merge_err <= 1'b1;
                    end
                    if (all_filled_c) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_data  <= tile_buf[0][0];
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= (ROWS * COLS == 1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            out_row  <= next_row_c;
                            out_col  <= next_col_c;
                            out_data <= tile_buf[next_row_c][next_col_c];
                            out_last <= (next_row_c == RW'(ROWS - 1)) &&
                                        (next_col_c == CW'(COLS - 1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recompute_result_merge.sv
// tb_recompute_result_merge
// Directed bench for recompute_result_merge (4x4 tile, 16-bit words, 4 RUs).
// Expected tile words are queued as the tile is built and checked word by
// word against the output stream, including hold behaviour while stalled.
module tb_recompute_result_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        STW_result_mat [0:3][0:3];
    logic        start;
    logic        arr_valid;
    logic [1:0]  arr_row;
    logic [1:0]  arr_col;
    logic [15:0] arr_data;
    logic [3:0]  ru_valid;
    logic [1:0]  ru_row    [0:3];
    logic [1:0]  ru_col    [0:3];
    logic [15:0] BottomOut [0:3];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        merge_err;

    recompute_result_merge dut (
        .clk(clk), .rst(rst), .STW_result_mat(STW_result_mat), .start(start),
        .arr_valid(arr_valid), .arr_row(arr_row), .arr_col(arr_col), .arr_data(arr_data),
        .ru_valid(ru_valid), .ru_row(ru_row), .ru_col(ru_col), .BottomOut(BottomOut),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .merge_err(merge_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [15:0] d;
        logic        last;
    } sb_t;

    sb_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] mdl_data [4][4];
    bit          mdl_fill [4][4];
    bit          mdl_mask [4][4];
    bit          exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"},  32'(out_data),  0);
        chk({tag, "_row"},   32'(out_row),   0);
        chk({tag, "_col"},   32'(out_col),   0);
        chk({tag, "_last"},  32'(out_last),  0);
        chk({tag, "_busy"},  32'(busy),      0);
        chk({tag, "_err"},   32'(merge_err), 0);
    endtask

    task automatic start_tile(input logic [15:0] m);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                STW_result_mat[r][c] = m[r*4+c];
                mdl_mask[r][c] = m[r*4+c];
                mdl_fill[r][c] = 1'b0;
                mdl_data[r][c] = '0;
            end
        end
        exp_err = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_err", 32'(merge_err), 0);
    endtask

    task automatic arr_wr(input logic [1:0] r, input logic [1:0] c, input logic [15:0] d);
        arr_valid = 1'b1; arr_row = r; arr_col = c; arr_data = d;
        if (!mdl_mask[r][c]) begin
            if (mdl_fill[r][c]) exp_err = 1'b1;
            else begin mdl_fill[r][c] = 1'b1; mdl_data[r][c] = d; end
        end
        tick();
        arr_valid = 1'b0;
    endtask

    // Model one RU write; callers apply lower indices first.
    task automatic ru_model(input logic [1:0] r, input logic [1:0] c, input logic [15:0] d);
        if (!mdl_mask[r][c] || mdl_fill[r][c]) exp_err = 1'b1;
        else begin mdl_fill[r][c] = 1'b1; mdl_data[r][c] = d; end
    endtask

    task automatic ru_drive(input int n, input logic [1:0] r, input logic [1:0] c,
                            input logic [15:0] d);
        ru_valid[n] = 1'b1; ru_row[n] = r; ru_col[n] = c; BottomOut[n] = d;
        ru_model(r, c, d);
    endtask

    task automatic fill_array(input logic [15:0] base, input logic [15:0] faulty_val);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                arr_wr(2'(r), 2'(c),
                       mdl_mask[r][c] ? faulty_val : 16'(base + 16'(r*16 + c)));
            end
        end
    endtask

    task automatic push_tile();
        sb_t e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.r = 2'(r); e.c = 2'(c); e.d = mdl_data[r][c];
                e.last = (r == 3 && c == 3);
                sb.push_back(e);
            end
        end
    endtask

    // mode 0: out_ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input string tag, input int mode);
        int  cyc = 0;
        int  hs = 0;
        sb_t e;
        while (!out_valid && cyc < 50) begin tick(); cyc++; end
        chk({tag, "_drain_start"}, 32'(out_valid), 1);
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            e = sb[0];
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_data"},  32'(out_data),  32'(e.d));
            chk({tag, "_row"},   32'(out_row),   32'(e.r));
            chk({tag, "_col"},   32'(out_col),   32'(e.c));
            chk({tag, "_last"},  32'(out_last),  32'(e.last));
            if (out_valid && out_ready) begin
                void'(sb.pop_front());
                hs++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        sb.delete();
        chk({tag, "_handshakes"}, 32'(hs), 16);
        if (mode == 0) chk({tag, "_drain_cycles"}, 32'(cyc), 16);
        chk({tag, "_post_valid"}, 32'(out_valid), 0);
        chk({tag, "_post_busy"},  32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; arr_valid = 1'b0; arr_row = '0; arr_col = '0;
        arr_data = '0; ru_valid = '0; out_ready = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ru_row[i] = '0; ru_col[i] = '0; BottomOut[i] = '0;
            for (int j = 0; j < 4; j++) STW_result_mat[i][j] = 1'b0;
        end
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: clean tile from the array alone, exact fill-to-drain latency.
        start_tile(16'h0000);
        fill_array(16'h0000, 16'h0000);
        chk("t1_not_yet_valid", 32'(out_valid), 0);
        tick();
        chk("t1_valid_after_detect", 32'(out_valid), 1);
        chk("t1_err", 32'(merge_err), 0);
        push_tile();
        drain("t1", 0);

        // 2: faulty (1,2),(3,0) repaired by RU0/RU1 in one cycle.
        start_tile(16'h1 << 6 | 16'h1 << 12);
        fill_array(16'h0000, 16'hDEAD);
        ru_drive(0, 2'd1, 2'd2, 16'h0A12);
        ru_drive(1, 2'd3, 2'd0, 16'h0A30);
        tick();
        ru_valid = '0;
        tick();
        chk("t2_err", 32'(merge_err), 0);
        push_tile();
        drain("t2", 0);

        // 3: RU to healthy cell and duplicate array write both flag errors.
        start_tile(16'h1 << 6 | 16'h1 << 12);
        fill_array(16'h0000, 16'hDEAD);
        ru_drive(0, 2'd0, 2'd0, 16'hBEEF);
        tick();
        ru_valid = '0;
        arr_wr(2'd2, 2'd2, 16'h7777);
        ru_drive(0, 2'd1, 2'd2, 16'h0B12);
        ru_drive(1, 2'd3, 2'd0, 16'h0B30);
        tick();
        ru_valid = '0;
        chk("t3_err", 32'(merge_err), 1);
        chk("t3_model_err", 32'(merge_err), 32'(exp_err));
        push_tile();
        drain("t3", 0);

        // 4: RU0 and RU2 collide on faulty (2,1); RU0 wins.
        start_tile(16'h1 << 9);
        fill_array(16'h0040, 16'hDEAD);
        ru_drive(0, 2'd2, 2'd1, 16'h1111);
        ru_drive(2, 2'd2, 2'd1, 16'h2222);
        tick();
        ru_valid = '0;
        chk("t4_err", 32'(merge_err), 1);
        push_tile();
        drain("t4", 0);

        // 5: stalled drain holds each word until accepted.
        start_tile(16'h0000);
        fill_array(16'h0500, 16'h0000);
        push_tile();
        drain("t5", 1);

        // 6: reset mid-tile discards it; writes while idle are ignored.
        start_tile(16'h0000);
        for (int k = 0; k < 7; k++) arr_wr(2'(k / 4), 2'(k % 4), 16'h00AA);
        rst = 1'b1;
        #2;
        check_reset_outputs("t6_rst");
        tick();
        rst = 1'b0;
        arr_valid = 1'b1; arr_row = 2'd0; arr_col = 2'd0; arr_data = 16'hFFFF;
        tick();
        arr_valid = 1'b0;
        chk("t6_idle_write_busy", 32'(busy), 0);
        chk("t6_idle_write_err", 32'(merge_err), 0);
        start_tile(16'h0000);
        fill_array(16'h0100, 16'h0000);
        push_tile();
        drain("t6", 0);
        chk("t6_err", 32'(merge_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recompute_result_merge.md
# recompute_result_merge

Downstream companion of the recompute stage. Collects one tile of PE results from the systolic array output and from the NUM_RU recompute units, substitutes recomputed values at every position flagged faulty by the STW test result, and streams the repaired ROWS×COLS tile out in row-major order over a valid/ready handshake. Sits between the array and recompute units and the accumulator/writeback path.

## Interface
- ROWS, 4, array rows
- COLS, 4, array columns
- WORD_SIZE, 16, result word width
- NUM_RU, 4, number of recompute units
- RW = $clog2(ROWS), CW = $clog2(COLS) (localparams, min 1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- STW_result_mat  in  1 per [0:ROWS-1][0:COLS-1]  fault map, 1 = faulty PE; sampled on start
- start  in  1  begin new tile (honoured only in IDLE)
- arr_valid  in  1  array result strobe
- arr_row / arr_col  in  RW / CW  array result position
- arr_data  in  WORD_SIZE  array result
- ru_valid  in  NUM_RU  per-RU result strobe
- ru_row[0:NUM_RU-1] / ru_col[0:NUM_RU-1]  in  RW / CW  RU result position
- BottomOut[0:NUM_RU-1]  in  WORD_SIZE  RU results
- out_valid  out  1  tile word available
- out_ready  in  1  consumer accepts
- out_data  out  WORD_SIZE  repaired result
- out_row / out_col  out  RW / CW  position of out_data
- out_last  out  1  final word of tile
- busy  out  1  state != IDLE
- merge_err  out  1  sticky protocol error

## Operation
- States IDLE, COLLECT, DRAIN. Storage: buf[ROWS][COLS] words, filled[ROWS][COLS] bits, latched mask[ROWS][COLS].
- IDLE: start=1 -> latch mask, clear filled, clear merge_err, go COLLECT.
- COLLECT, array write (arr_valid): position in range, mask=0, filled=0 -> store, set filled. mask=1 -> dropped silently (faulty PE output). filled=1 -> dropped, merge_err=1.
- COLLECT, RU write (ru_valid[n]): position in range, mask=1, filled=0 -> store, set filled. mask=0 or filled=1 -> dropped, merge_err=1.
- Several RUs addressing same cell same cycle: lowest index n wins; others dropped, merge_err=1. Array and RU cannot legally collide (mask disjoint).
- Out-of-range row/col (non-power-of-2 dims): dropped, merge_err=1.
- All filled bits set -> DRAIN; index idx=0.
- DRAIN: out_valid=1, out_data=buf[idx], out_row/out_col from idx, out_last=(idx==ROWS*COLS-1). On out_valid&&out_ready: idx++; on last word -> IDLE.
- start ignored in COLLECT/DRAIN. Array/RU writes ignored in IDLE/DRAIN (no error).
- merge_err sticky until next accepted start or rst.

## Timing
- Reset: state IDLE, out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, busy 0, merge_err 0, filled cleared.
- start sampled at edge E -> busy=1 after E; writes accepted from edge E+1.
- Write in cycle N is stored at edge ending N. If it completes the tile (edge F), state=DRAIN after edge F+1 (one cycle full-detect); out_valid high from then.
- Output registered; out_data/row/col/last stable while out_valid&&!out_ready. One word per cycle with out_ready held high; tile drain = ROWS*COLS cycles.
- After last handshake at edge L: out_valid=0, busy=0 after L; start in cycle after L accepted.
- rst mid-tile: immediate abort to reset values; partial tile discarded.
- All-zero mask: tile completes from array alone. All-ones mask: from RUs alone.

## Test plan
- Mask all 0, array writes cells in order with data=r*16+c -> 16 words out row-major, values 0x00..0x33, out_last on 16th, merge_err=0.
- Mask (1,2),(3,0) faulty; array writes all 16 incl. 0xDEAD at faulty cells; RU0/RU1 write 0x0A12, 0x0A30 -> outputs at (1,2)=0x0A12, (3,0)=0x0A30, no 0xDEAD, merge_err=0.
- RU write to non-faulty (0,0) and duplicate array write to (2,2) -> merge_err=1, first values kept, tile still completes.
- RU0 and RU2 same faulty cell same cycle, 0x1111/0x2222 -> 0x1111 stored, merge_err=1.
- Drain with out_ready toggling 1,0,0,1… -> outputs held while stalled, no loss/duplication, 16 handshakes total.
- rst asserted after 7 fills -> all outputs 0, busy 0; new start then full tile drains correctly.
